// File: rtl/axis_2d_line_sequencer.sv
// Splits a 2D transfer descriptor into one linear command per line and gates
// the pixel stream so exactly one line's beats pass while that line's command is open.
module axis_2d_line_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  s_dvalid,
    input  logic [ADDR_WIDTH-1:0] s_daddr,
    input  logic [LINE_WIDTH-1:0] s_dlines,
    input  logic [ADDR_WIDTH-1:0] s_dbeats,
    input  logic [ADDR_WIDTH-1:0] s_dstride,
    output logic                  s_dready,
    output logic                  done,
    output logic                  m_avalid,
    output logic [ADDR_WIDTH-1:0] m_aaddr,
    output logic [ADDR_WIDTH-1:0] m_abeats,
    input  logic                  m_aready,
    input  logic [DATA_WIDTH-1:0] s_xdata,
    input  logic [STRB_WIDTH-1:0] s_xstrb,
    input  logic                  s_xvalid,
    output logic                  s_xready,
    output logic [DATA_WIDTH-1:0] m_xdata,
    output logic [STRB_WIDTH-1:0] m_xstrb,
    output logic                  m_xlast,
    output logic                  m_xvalid,
    input  logic                  m_xready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LINE,
        S_NEXT,
        S_FIN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_aaddr;
    logic [ADDR_WIDTH-1:0] r_abeats;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [LINE_WIDTH-1:0] r_lines;
    logic [LINE_WIDTH-1:0] r_line_cnt;
    logic [ADDR_WIDTH-1:0] r_beat_cnt;
    logic                  r_cmd_done;

    logic w_gate_open;
    logic w_beat;
    logic w_last_beat;
    logic w_beats_done;
    logic w_line_done;
    logic w_final_line;
    logic w_desc_zero;

    always_comb begin
        w_gate_open  = (r_state == S_LINE) && (r_beat_cnt < r_abeats);
        w_beat       = w_gate_open && s_xvalid && m_xready;
        w_last_beat  = w_gate_open && (r_beat_cnt == (r_abeats - ADDR_WIDTH'(1)));
        // Final beat and m_aready in the same cycle still completes the line now.
        w_beats_done = (r_beat_cnt == r_abeats) || (w_beat && w_last_beat);
        w_line_done  = (r_cmd_done || m_aready) && w_beats_done;
        // One extra bit so a line count of all-ones still terminates.
        w_final_line = ({1'b0, r_line_cnt} + (LINE_WIDTH + 1)'(1)) == {1'b0, r_lines};
        w_desc_zero  = (s_dlines == '0) || (s_dbeats == '0);
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_dready    = 1'b0;
        done        = 1'b0;
        m_avalid    = 1'b0;
        m_xvalid    = 1'b0;
        s_xready    = 1'b0;
        m_xlast     = 1'b0;
        m_xdata     = s_xdata;
        m_xstrb     = s_xstrb;
        m_aaddr     = r_aaddr;
        m_abeats    = r_abeats;
        case (r_state)
            S_IDLE: begin
                s_dready = 1'b1;
                if (s_dvalid) begin
                    w_state_nxt = w_desc_zero ? S_FIN : S_LINE;
                end
            end
            S_LINE: begin
                m_avalid = !r_cmd_done;
                m_xvalid = w_gate_open && s_xvalid;
                s_xready = w_gate_open && m_xready;
                m_xlast  = w_last_beat;
                if (w_line_done) begin
                    w_state_nxt = w_final_line ? S_FIN : S_NEXT;
                end
            end
            S_NEXT:  w_state_nxt = S_LINE;
            S_FIN: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_aaddr    <= '0;
            r_abeats   <= '0;
            r_stride   <= '0;
            r_lines    <= '0;
            r_line_cnt <= '0;
            r_beat_cnt <= '0;
            r_cmd_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s_dvalid) begin
                        r_aaddr    <= s_daddr;
                        r_abeats   <= s_dbeats;
                        r_stride   <= s_dstride;
                        r_lines    <= s_dlines;
                        r_line_cnt <= '0;
                        r_beat_cnt <= '0;
                        r_cmd_done <= 1'b0;
                    end
                end
                S_LINE: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + ADDR_WIDTH'(1);
                    end
                    if (m_aready) begin
                        r_cmd_done <= 1'b1;
                    end
                end
                S_NEXT: begin
                    r_aaddr    <= r_aaddr + r_stride;
                    r_line_cnt <= r_line_cnt + LINE_WIDTH'(1);
                    r_beat_cnt <= '0;
                    r_cmd_done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_2d_line_sequencer.sv
// Directed bench for axis_2d_line_sequencer: a transaction-level model predicts
// commands, the beat stream, the gate and done; checked every cycle mid-period.
module tb_axis_2d_line_sequencer;

    localparam int DW = 32;
    localparam int SW = 4;
    localparam int AW = 32;
    localparam int LW = 16;

    logic          aclk = 1'b0;
    logic          resetn = 1'b0;
    logic          s_dvalid = 1'b0;
    logic [AW-1:0] s_daddr = '0;
    logic [LW-1:0] s_dlines = '0;
    logic [AW-1:0] s_dbeats = '0;
    logic [AW-1:0] s_dstride = '0;
    logic          s_dready;
    logic          done;
    logic          m_avalid;
    logic [AW-1:0] m_aaddr;
    logic [AW-1:0] m_abeats;
    logic          m_aready = 1'b0;
    logic [DW-1:0] s_xdata = '0;
    logic [SW-1:0] s_xstrb = '0;
    logic          s_xvalid = 1'b0;
    logic          s_xready;
    logic [DW-1:0] m_xdata;
    logic [SW-1:0] m_xstrb;
    logic          m_xlast;
    logic          m_xvalid;
    logic          m_xready = 1'b0;

    axis_2d_line_sequencer #(
        .DATA_WIDTH(DW),
        .STRB_WIDTH(SW),
        .ADDR_WIDTH(AW),
        .LINE_WIDTH(LW)
    ) dut (
        .aclk(aclk), .resetn(resetn),
        .s_dvalid(s_dvalid), .s_daddr(s_daddr), .s_dlines(s_dlines),
        .s_dbeats(s_dbeats), .s_dstride(s_dstride), .s_dready(s_dready),
        .done(done),
        .m_avalid(m_avalid), .m_aaddr(m_aaddr), .m_abeats(m_abeats), .m_aready(m_aready),
        .s_xdata(s_xdata), .s_xstrb(s_xstrb), .s_xvalid(s_xvalid), .s_xready(s_xready),
        .m_xdata(m_xdata), .m_xstrb(m_xstrb), .m_xlast(m_xlast), .m_xvalid(m_xvalid),
        .m_xready(m_xready)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [31:0] d; bit l; } beat_t;
    typedef struct { logic [31:0] a; logic [31:0] b; } cmd_t;

    int checks = 0;
    int failures = 0;

    logic [31:0] src_q[$];
    beat_t       exp_q[$];
    cmd_t        cmd_q[$];
    logic [31:0] cmd_log[$];
    bit          last_log[$];

    bit busy, cmd_active, exp_done_next, pend_aready, bp_mode, rnd_mode;
    int gap, cur_beats, line_beats, out_beats, done_cnt, cyc, stall_cnt;
    int hs_cyc, done_cyc, last_aready_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] strb_of(input logic [31:0] d);
        return d[3:0] ^ d[7:4];
    endfunction

    // Per-cycle driver and checker: drive on the falling edge, check 1 ns later.
    initial begin
        forever begin
            @(negedge aclk);
            cyc++;
            m_aready    = pend_aready;
            pend_aready = 1'b0;
            m_xready    = bp_mode ? ~m_xready : 1'b1;
            if (src_q.size() > 0 && (!rnd_mode || $urandom_range(0, 1) == 1)) begin
                s_xvalid = 1'b1;
                s_xdata  = src_q[0];
                s_xstrb  = strb_of(src_q[0]);
            end else begin
                s_xvalid = 1'b0;
                s_xdata  = '0;
                s_xstrb  = '0;
            end
            #1;
            if (!resetn) begin
                busy = 0; cmd_active = 0; gap = 0; exp_done_next = 0;
                pend_aready = 0; line_beats = 0;
                src_q.delete(); exp_q.delete(); cmd_q.delete();
                continue;
            end
            chk("s_dready", s_dready, !busy);
            chk("done", done, exp_done_next);
            exp_done_next = 0;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                busy = 0;
            end
            if (gap > 0) begin
                gap--;
                if (gap == 0) begin
                    chk("avalid_rise", m_avalid, 1);
                    chk("cmd_expected", cmd_q.size() > 0, 1);
                    if (cmd_q.size() > 0) begin
                        cmd_t c;
                        c = cmd_q.pop_front();
                        chk("m_aaddr", m_aaddr, c.a);
                        chk("m_abeats", m_abeats, c.b);
                        cur_beats = int'(c.b);
                    end
                    cmd_log.push_back(m_aaddr);
                    cmd_active = 1;
                    line_beats = 0;
                end else begin
                    chk("avalid_gap", m_avalid, 0);
                end
            end else begin
                chk("m_avalid", m_avalid, cmd_active);
            end
            begin
                bit gate;
                gate = cmd_active && (line_beats < cur_beats);
                chk("m_xvalid", m_xvalid, gate ? s_xvalid : 1'b0);
                chk("s_xready", s_xready, gate ? m_xready : 1'b0);
            end
            if (busy && s_xvalid && !s_xready) stall_cnt++;
            if (s_xvalid && s_xready && src_q.size() > 0) void'(src_q.pop_front());
            if (m_xvalid && m_xready) begin
                chk("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("m_xdata", m_xdata, e.d);
                    chk("m_xstrb", m_xstrb, strb_of(e.d));
                    chk("m_xlast", m_xlast, e.l);
                end
                last_log.push_back(m_xlast);
                out_beats++;
                line_beats++;
                if (line_beats == cur_beats) pend_aready = 1'b1;
            end
            if (m_aready) last_aready_cyc = cyc;
            if (m_aready && cmd_active) begin
                cmd_active = 0;
                if (cmd_q.size() > 0) gap = 2;
                else exp_done_next = 1;
            end
            if (s_dvalid && s_dready) begin
                busy   = 1;
                hs_cyc = cyc;
                if (cmd_q.size() == 0) exp_done_next = 1;
                else gap = 1;
            end
        end
    end

    task automatic issue_desc(input logic [31:0] addr, input logic [15:0] lines,
                              input logic [31:0] beats, input logic [31:0] stride,
                              input logic [15:0] tag);
        int n = 0;
        if (beats != 0) begin
            for (int l = 0; l < int'(lines); l++) begin
                cmd_q.push_back('{addr + 32'(l) * stride, beats});
                for (int b = 0; b < int'(beats); b++) begin
                    logic [31:0] w;
                    w = {tag, 16'(n)};
                    n++;
                    src_q.push_back(w);
                    exp_q.push_back('{w, (b == int'(beats) - 1)});
                end
            end
        end
        @(negedge aclk);
        s_daddr = addr; s_dlines = lines; s_dbeats = beats; s_dstride = stride;
        s_dvalid = 1'b1;
        @(negedge aclk);
        s_dvalid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start;
        bit seen;
        start = done_cnt;
        seen  = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge aclk);
            #2;
            if (done_cnt != start) begin
                seen = 1;
                break;
            end
        end
        chk({name, "_done_seen"}, seen, 1);
        repeat (3) @(negedge aclk);
        #2;
        chk({name, "_done_once"}, done_cnt - start, 1);
        chk({name, "_beats_left"}, exp_q.size(), 0);
        chk({name, "_cmds_left"}, cmd_q.size(), 0);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_s_dready"}, s_dready, 1);
        chk({name, "_done"}, done, 0);
        chk({name, "_m_avalid"}, m_avalid, 0);
        chk({name, "_m_aaddr"}, m_aaddr, 0);
        chk({name, "_m_abeats"}, m_abeats, 0);
        chk({name, "_m_xvalid"}, m_xvalid, 0);
        chk({name, "_s_xready"}, s_xready, 0);
        chk({name, "_m_xlast"}, m_xlast, 0);
    endtask

    task automatic clear_logs();
        cmd_log.delete();
        last_log.delete();
        stall_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] last_mask;
        int ob0;
        repeat (3) @(negedge aclk);
        #2;
        chk_reset("reset");
        @(negedge aclk);
        resetn = 1'b1;

        // Basic 2D
        clear_logs();
        issue_desc(32'h1000, 16'd3, 32'd4, 32'h100, 16'hA000);
        wait_done("basic");
        chk("basic_ncmd", cmd_log.size(), 3);
        chk("basic_cmd0", cmd_log[0], 32'h1000);
        chk("basic_cmd1", cmd_log[1], 32'h1100);
        chk("basic_cmd2", cmd_log[2], 32'h1200);
        chk("basic_nbeats", last_log.size(), 12);
        last_mask = 12'h888;
        for (int i = 0; i < 12; i++) chk("basic_last_pos", last_log[i], last_mask[i]);
        chk("basic_done_lat", done_cyc - last_aready_cyc, 1);

        // Backpressure
        clear_logs();
        bp_mode = 1; rnd_mode = 1;
        issue_desc(32'h1000, 16'd3, 32'd4, 32'h100, 16'hB000);
        wait_done("bp");
        chk("bp_nbeats", last_log.size(), 12);
        bp_mode = 0; rnd_mode = 0;

        // Excess input: all 8 beats offered up front, beat 5 must wait for line 2
        clear_logs();
        issue_desc(32'h4000, 16'd2, 32'd4, 32'h20, 16'hE000);
        wait_done("excess");
        chk("excess_stalled", stall_cnt > 0, 1);
        chk("excess_beat5_notlast", last_log[4], 0);
        chk("excess_cmd1", cmd_log[1], 32'h4020);

        // Zero cases
        clear_logs();
        issue_desc(32'h5000, 16'd0, 32'd4, 32'h10, 16'h0);
        wait_done("zlines");
        chk("zlines_lat", done_cyc - hs_cyc, 1);
        chk("zlines_nocmd", cmd_log.size(), 0);
        clear_logs();
        issue_desc(32'h5000, 16'd5, 32'd0, 32'h10, 16'h0);
        wait_done("zbeats");
        chk("zbeats_lat", done_cyc - hs_cyc, 1);
        chk("zbeats_nocmd", cmd_log.size(), 0);

        // Address wrap
        clear_logs();
        issue_desc(32'hFFFF_FF00, 16'd2, 32'd2, 32'h100, 16'hF000);
        wait_done("wrap");
        chk("wrap_cmd0", cmd_log[0], 32'hFFFF_FF00);
        chk("wrap_cmd1", cmd_log[1], 32'h0000_0000);

        // Reset mid-line after two beats
        clear_logs();
        ob0 = out_beats;
        issue_desc(32'h2000, 16'd2, 32'd4, 32'h40, 16'hC000);
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            #2;
            if (out_beats - ob0 >= 2) break;
        end
        chk("rst_two_beats", out_beats - ob0, 2);
        @(negedge aclk);
        resetn = 1'b0;
        #2;
        chk_reset("rst_mid");
        repeat (2) @(negedge aclk);
        resetn = 1'b1;
        #2;
        chk("rst_release_dready", s_dready, 1);
        clear_logs();
        issue_desc(32'h3000, 16'd2, 32'd3, 32'h80, 16'hD000);
        wait_done("post_rst");
        chk("post_rst_cmd0", cmd_log[0], 32'h3000);
        chk("post_rst_cmd1", cmd_log[1], 32'h3080);
        chk("post_rst_nbeats", last_log.size(), 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
